writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_if.sv | 35 +++
 rtl/writeback_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_if
// Brief    : Producer-side request bundle and register-file write port of the
//            writeback arbiter.
// Revision : 1.0
// ============================================================================
interface writeback_arbiter_if #(
    parameter int NCH = 2,
    parameter int W   = 32
);
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*W-1:0]  in_data;
    logic [NCH*5-1:0]  in_adr;
    logic [NCH*3-1:0]  in_ext;
    logic [NCH*2-1:0]  in_off;
    logic [NCH*32-1:0] in_pc;
    logic [W-1:0]      reg_write;
    logic [4:0]        regw_adr;
    logic              regw_enable;
    logic [31:0]       W_PC;
    logic [31:0]       pending;

    modport master (
        output in_valid, in_data, in_adr, in_ext, in_off, in_pc,
        input  in_ready, reg_write, regw_adr, regw_enable, W_PC, pending
    );

    modport slave (
        input  in_valid, in_data, in_adr, in_ext, in_off, in_pc,
        output in_ready, reg_write, regw_adr, regw_enable, W_PC, pending
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Per-channel writeback FIFOs, round-robin single-port register
//            write with load extension, and per-register in-flight tracking.
// Revision : 1.0
// ============================================================================
module writeback_arbiter #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    writeback_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int KW = $clog2(NCH*DEPTH+2);

    logic [NCH-1:0]         w_full;
    logic [NCH-1:0]         w_empty;
    logic [NCH-1:0]         w_push;
    logic [NCH-1:0]         w_pop;
    logic [NCH-1:0][W-1:0]  w_head_data;
    logic [NCH-1:0][4:0]    w_head_adr;
    logic [NCH-1:0][2:0]    w_head_ext;
    logic [NCH-1:0][1:0]    w_head_off;
    logic [NCH-1:0][31:0]   w_head_pc;

    logic                   w_grant_vld;
    logic [CW-1:0]          w_grant;
    logic [CW-1:0]          r_last;

    logic [W-1:0]           w_sel_data;
    logic [2:0]             w_sel_ext;
    logic [1:0]             w_sel_off;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [W-1:0]           w_ext_data;

    logic                   r_regw_enable;
    logic [4:0]             r_regw_adr;
    logic [W-1:0]           r_reg_write;
    logic [31:0]            r_w_pc;

    logic [KW-1:0]          r_cnt     [1:31];
    logic [KW-1:0]          w_cnt_nxt [1:31];
    logic [31:0]            w_pending;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [PW:0]   r_wr_ptr;
            logic [PW:0]   r_rd_ptr;
            logic [W-1:0]  r_data [DEPTH];
            logic [4:0]    r_adr  [DEPTH];
            logic [2:0]    r_ext  [DEPTH];
            logic [1:0]    r_off  [DEPTH];
            logic [31:0]   r_pc   [DEPTH];

            assign w_empty[c] = (r_wr_ptr == r_rd_ptr);
            assign w_full[c]  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                                (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
            // Zero-address requests complete the handshake but never enqueue.
            assign w_push[c]  = bus.in_valid[c] && !w_full[c] &&
                                (bus.in_adr[c*5 +: 5] != 5'd0);
            assign w_pop[c]   = w_grant_vld && (w_grant == CW'(c));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[c]) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop[c])  r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[c]) begin
                    r_data[r_wr_ptr[PW-1:0]] <= bus.in_data[c*W +: W];
                    r_adr[r_wr_ptr[PW-1:0]]  <= bus.in_adr[c*5 +: 5];
                    r_ext[r_wr_ptr[PW-1:0]]  <= bus.in_ext[c*3 +: 3];
                    r_off[r_wr_ptr[PW-1:0]]  <= bus.in_off[c*2 +: 2];
                    r_pc[r_wr_ptr[PW-1:0]]   <= bus.in_pc[c*32 +: 32];
                end
            end

            assign w_head_data[c] = r_data[r_rd_ptr[PW-1:0]];
            assign w_head_adr[c]  = r_adr[r_rd_ptr[PW-1:0]];
            assign w_head_ext[c]  = r_ext[r_rd_ptr[PW-1:0]];
            assign w_head_off[c]  = r_off[r_rd_ptr[PW-1:0]];
            assign w_head_pc[c]   = r_pc[r_rd_ptr[PW-1:0]];
        end
    endgenerate

    // Two passes: channels above the last grant first, then wrap to 0..last.
    always_comb begin : p_arb
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!w_grant_vld && !w_empty[c] && (CW'(c) > r_last)) begin
                w_grant_vld = 1'b1;
                w_grant     = CW'(c);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!w_grant_vld && !w_empty[c] && (CW'(c) <= r_last)) begin
                w_grant_vld = 1'b1;
                w_grant     = CW'(c);
            end
        end
    end

    assign w_sel_data = w_head_data[w_grant];
    assign w_sel_ext  = w_head_ext[w_grant];
    assign w_sel_off  = w_head_off[w_grant];

    always_comb begin : p_ext
        w_byte = 8'd0;
        case (w_sel_off)
            2'd0:    w_byte = w_sel_data[7:0];
            2'd1:    w_byte = w_sel_data[15:8];
            2'd2:    w_byte = w_sel_data[23:16];
            default: w_byte = w_sel_data[31:24];
        endcase
        w_half = w_sel_off[1] ? w_sel_data[31:16] : w_sel_data[15:0];
        case (w_sel_ext)
            3'd1:    w_ext_data = {{(W-8){1'b0}}, w_byte};
            3'd2:    w_ext_data = {{(W-8){w_byte[7]}}, w_byte};
            3'd3:    w_ext_data = {{(W-16){1'b0}}, w_half};
            3'd4:    w_ext_data = {{(W-16){w_half[15]}}, w_half};
            default: w_ext_data = w_sel_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regw_enable <= 1'b0;
            r_regw_adr    <= 5'd0;
            r_reg_write   <= '0;
            r_w_pc        <= 32'd0;
            r_last        <= CW'(NCH-1);
        end else if (w_grant_vld) begin
            r_regw_enable <= 1'b1;
            r_regw_adr    <= w_head_adr[w_grant];
            r_reg_write   <= w_ext_data;
            r_w_pc        <= w_head_pc[w_grant];
            r_last        <= w_grant;
        end else begin
            r_regw_enable <= 1'b0;
            r_regw_adr    <= 5'd0;
            r_reg_write   <= '0;
            r_w_pc        <= 32'd0;
        end
    end

    // A register stays pending from accept until its write cycle has ended.
    always_comb begin : p_cnt
        for (int r = 1; r < 32; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            for (int c = 0; c < NCH; c++) begin
                if (w_push[c] && (bus.in_adr[c*5 +: 5] == 5'(r)))
                    w_cnt_nxt[r] = w_cnt_nxt[r] + KW'(1);
            end
            if (r_regw_enable && (r_regw_adr == 5'(r)))
                w_cnt_nxt[r] = w_cnt_nxt[r] - KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 1; r < 32; r++) begin
            if (reset) r_cnt[r] <= '0;
            else       r_cnt[r] <= w_cnt_nxt[r];
        end
    end

    always_comb begin : p_pend
        w_pending = 32'd0;
        for (int r = 1; r < 32; r++) begin
            w_pending[r] = (r_cnt[r] != '0);
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.regw_enable = r_regw_enable;
    assign bus.regw_adr    = r_regw_adr;
    assign bus.reg_write   = r_reg_write;
    assign bus.W_PC        = r_w_pc;
    assign bus.pending     = w_pending;
endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Brief    : Directed and randomized checks of writeback_arbiter against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_writeback_arbiter;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NCH(NCH), .W(W)) bus ();

    writeback_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic [4:0]  adr;
        logic [2:0]  ext;
        logic [1:0]  off;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_last;
    logic        exp_en;
    logic [4:0]  exp_adr;
    logic [31:0] exp_data;
    logic [31:0] exp_pc;
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wb_extend(input logic [31:0] d, input logic [2:0] e,
                                              input logic [1:0] o);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * o)) & 32'h0000_00FF;
        h = (d >> (16 * o[1])) & 32'h0000_FFFF;
        case (e)
            3'd1:    return b;
            3'd2:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd3:    return h;
            3'd4:    return h[15] ? (h | 32'hFFFF_0000) : h;
            default: return d;
        endcase
    endfunction

    function automatic int ch_count(input int c);
        int n = 0;
        foreach (mq[i]) if (mq[i].ch == c) n++;
        return n;
    endfunction

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        bit rdy [NCH];
        bit found;
        int hit;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_last   = NCH - 1;
            exp_en   = 1'b0;
            exp_adr  = 5'd0;
            exp_data = 32'd0;
            exp_pc   = 32'd0;
            return;
        end
        for (int c = 0; c < NCH; c++) rdy[c] = (ch_count(c) < DEPTH);
        found    = 1'b0;
        exp_en   = 1'b0;
        exp_adr  = 5'd0;
        exp_data = 32'd0;
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c   = (m_last + i) % NCH;
            hit = -1;
            foreach (mq[k]) if (hit < 0 && mq[k].ch == c) hit = k;
            if (!found && hit >= 0) begin
                e        = mq[hit];
                mq.delete(hit);
                found    = 1'b1;
                m_last   = c;
                exp_en   = 1'b1;
                exp_adr  = e.adr;
                exp_data = wb_extend(e.data, e.ext, e.off);
                exp_pc   = e.pc;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_valid[c] && rdy[c] && bus.in_adr[c*5 +: 5] != 5'd0) begin
                e.ch   = c;
                e.data = bus.in_data[c*W +: W];
                e.adr  = bus.in_adr[c*5 +: 5];
                e.ext  = bus.in_ext[c*3 +: 3];
                e.off  = bus.in_off[c*2 +: 2];
                e.pc   = bus.in_pc[c*32 +: 32];
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0]    p;
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = (ch_count(c) < DEPTH);
        p = 32'd0;
        foreach (mq[i]) p[mq[i].adr] = 1'b1;
        if (exp_en) p[exp_adr] = 1'b1;
        p[0] = 1'b0;
        chk("in_ready",    32'(bus.in_ready),    32'(r));
        chk("regw_enable", 32'(bus.regw_enable), 32'(exp_en));
        chk("regw_adr",    32'(bus.regw_adr),    32'(exp_adr));
        chk("reg_write",   bus.reg_write,        exp_data);
        if (exp_en) chk("W_PC", bus.W_PC, exp_pc);
        chk("pending",     bus.pending,          p);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_adr   = '0;
        bus.in_ext   = '0;
        bus.in_off   = '0;
        bus.in_pc    = '0;
    endtask

    task automatic set_ch(input int c, input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic [2:0] e, input logic [1:0] o, input logic [31:0] pc);
        bus.in_valid[c]          = v;
        bus.in_data[c*W +: W]    = d;
        bus.in_adr[c*5 +: 5]     = a;
        bus.in_ext[c*3 +: 3]     = e;
        bus.in_off[c*2 +: 2]     = o;
        bus.in_pc[c*32 +: 32]    = pc;
    endtask

    task automatic ext_case(input logic [2:0] e, input logic [1:0] o, input logic [31:0] expv);
        set_ch(0, 1'b1, 32'h0000_80FF, 5'd3, e, o, 32'h100);
        tick();
        idle_inputs();
        tick();
        chk("ext_result", bus.reg_write, expv);
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Single write through the pipeline.
        set_ch(0, 1'b1, 32'h1234_5678, 5'd5, 3'd0, 2'd0, 32'h0000_0040);
        tick();
        chk("pend5_set", 32'(bus.pending[5]), 32'd1);
        idle_inputs();
        tick();
        chk("wr_en",   32'(bus.regw_enable), 32'd1);
        chk("wr_adr",  32'(bus.regw_adr),    32'd5);
        chk("wr_data", bus.reg_write,        32'h1234_5678);
        tick();
        chk("pend5_clr", 32'(bus.pending[5]), 32'd0);

        ext_case(3'd2, 2'd1, 32'hFFFF_FF80);
        ext_case(3'd1, 2'd0, 32'h0000_00FF);
        ext_case(3'd4, 2'd0, 32'hFFFF_80FF);
        ext_case(3'd3, 2'd2, 32'h0000_0000);

        // Both channels streaming from reset: grants alternate starting at ch0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 16; n++) begin
            set_ch(0, 1'b1, 32'(n),         5'd10, 3'd0, 2'd0, 32'(n));
            set_ch(1, 1'b1, 32'(n + 100),   5'd20, 3'd0, 2'd0, 32'(n + 100));
            tick();
            if (n == 1) chk("rr_first", 32'(bus.regw_adr), 32'd10);
            if (n == 2) chk("rr_second", 32'(bus.regw_adr), 32'd20);
            if (n == 3) chk("rr_third", 32'(bus.regw_adr), 32'd10);
        end
        chk("ch1_full", 32'(bus.in_ready[1]), 32'd0);
        idle_inputs();
        for (int n = 0; n < 20; n++) tick();

        // Zero-address request is swallowed.
        set_ch(0, 1'b1, 32'hDEAD_BEEF, 5'd0, 3'd0, 2'd0, 32'h0);
        tick();
        idle_inputs();
        tick();
        chk("adr0_en",   32'(bus.regw_enable), 32'd0);
        chk("adr0_pend", bus.pending,          32'd0);

        // Reset with entries queued.
        set_ch(0, 1'b1, 32'h11, 5'd7, 3'd0, 2'd0, 32'h0);
        set_ch(1, 1'b1, 32'h22, 5'd8, 3'd0, 2'd0, 32'h0);
        tick();
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_en",    32'(bus.regw_enable), 32'd0);
        chk("rst_pend",  bus.pending,          32'd0);
        chk("rst_ready", 32'(bus.in_ready),    32'(2'b11));

        for (int n = 0; n < 3000; n++) begin
            int rate;
            rate  = (((n / 500) % 3) == 0) ? 25 : ((((n / 500) % 3) == 1) ? 60 : 95);
            reset = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NCH; c++) begin
                set_ch(c, ($urandom_range(0, 99) < rate), $urandom,
                       5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), $urandom);
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        for (int n = 0; n < 20; n++) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
